// File: rtl/alu_ex_issue.sv
// ID/EX issue register for the arithmetic ALU: operand select/extension,
// one-level result bypass and op-to-select encoding behind a valid/ready handshake.
module alu_ex_issue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [RADDR-1:0] in_rs1,
    input  logic [RADDR-1:0] in_rs2,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_use_imm,
    input  logic [15:0]      in_imm,
    input  logic             in_imm_signed,
    input  logic             fwd_valid,
    input  logic [RADDR-1:0] fwd_rd,
    input  logic [XLEN-1:0]  fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [4:0]       out_ctrl,
    output logic [RADDR-1:0] out_rd
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SEQ = 3'd2,
        OP_SNE = 3'd3,
        OP_SLT = 3'd4,
        OP_SGT = 3'd5,
        OP_SLE = 3'd6,
        OP_SGE = 3'd7
    } op_e;

    logic            capture;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [4:0]      ctrl;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Register 0 is hardwired, so a bypass hit on it must never override the file value.
    always_comb begin
        imm_ext = in_imm_signed ? {{(XLEN-16){in_imm[15]}}, in_imm}
                                : {{(XLEN-16){1'b0}}, in_imm};
        opa = in_rs1_data;
        if (fwd_valid && (fwd_rd == in_rs1) && (in_rs1 != '0))
            opa = fwd_data;
        opb = in_rs2_data;
        if (in_use_imm)
            opb = imm_ext;
        else if (fwd_valid && (fwd_rd == in_rs2) && (in_rs2 != '0))
            opb = fwd_data;
    end

    always_comb begin
        ctrl = '0;
        case (op_e'(in_op))
            OP_ADD:  ctrl = 5'b00000;
            OP_SUB:  ctrl = 5'b11000;
            OP_SEQ:  ctrl = 5'b10000;
            OP_SNE:  ctrl = 5'b10001;
            OP_SLT:  ctrl = 5'b10010;
            OP_SGT:  ctrl = 5'b10011;
            OP_SLE:  ctrl = 5'b10100;
            OP_SGE:  ctrl = 5'b10110;
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ctrl  <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_a     <= opa;
            out_b     <= opb;
            out_ctrl  <= ctrl;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ex_issue.sv
// Self-checking bench for alu_ex_issue: directed vector table, handshake corner
// sequences and a randomized run against a behavioural model of the stage.
module tb_alu_ex_issue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RADDR = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic [RADDR-1:0] in_rs1;
    logic [RADDR-1:0] in_rs2;
    logic [RADDR-1:0] in_rd;
    logic             in_use_imm;
    logic [15:0]      in_imm;
    logic             in_imm_signed;
    logic             fwd_valid;
    logic [RADDR-1:0] fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;
    logic [4:0]       out_ctrl;
    logic [RADDR-1:0] out_rd;

    alu_ex_issue #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_imm_signed(in_imm_signed),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [4:0] enc [8];

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data;
        logic        use_imm;
        logic [15:0] imm;
        logic        imm_signed;
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fdata;
        logic [31:0] exp_a, exp_b;
        logic [4:0]  exp_ctrl;
    } vec_t;

    vec_t vecs [8];

    // Behavioural model of what the ALU should see after each edge.
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_ctrl, m_rd;

    function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] rf);
        if (fwd_valid && rs != 0 && rs == fwd_rd) return fwd_data;
        return rf;
    endfunction

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_op = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_use_imm = 0; in_imm = 0;
        in_imm_signed = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0; out_ready = 1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] a);
        in_valid = 1; in_op = op; in_rd = rd; in_rs1 = 1; in_rs1_data = a;
        in_rs2 = 2; in_rs2_data = ~a; in_use_imm = 0; fwd_valid = 0;
    endtask

    initial begin
        enc[0] = 5'b00000; enc[1] = 5'b11000; enc[2] = 5'b10000; enc[3] = 5'b10001;
        enc[4] = 5'b10010; enc[5] = 5'b10011; enc[6] = 5'b10100; enc[7] = 5'b10110;

        //           op  rs1 rs2 rd  rs1_data      rs2_data      imm? imm       sgn fv frd fdata   exp_a         exp_b         ctrl
        vecs[0] = '{3'd1, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 1'b0, 16'h0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd10, 32'd3, 5'b11000};
        vecs[1] = '{3'd0, 5'd1, 5'd2, 5'd6, 32'd7, 32'd8, 1'b1, 16'hFFFE, 1'b1, 1'b0, 5'd0, 32'd0, 32'd7, 32'hFFFFFFFE, 5'b00000};
        vecs[2] = '{3'd0, 5'd1, 5'd2, 5'd6, 32'd7, 32'd8, 1'b1, 16'hFFFE, 1'b0, 1'b0, 5'd0, 32'd0, 32'd7, 32'h0000FFFE, 5'b00000};
        vecs[3] = '{3'd2, 5'd5, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 16'h0, 1'b0, 1'b1, 5'd5, 32'd99, 32'd99, 32'd2, 5'b10000};
        vecs[4] = '{3'd3, 5'd0, 5'd2, 5'd3, 32'd1, 32'd2, 1'b0, 16'h0, 1'b0, 1'b1, 5'd0, 32'd99, 32'd1, 32'd2, 5'b10001};
        vecs[5] = '{3'd5, 5'd1, 5'd9, 5'd7, 32'd11, 32'd12, 1'b0, 16'h0, 1'b0, 1'b1, 5'd9, 32'hABCD, 32'd11, 32'hABCD, 5'b10011};
        vecs[6] = '{3'd6, 5'd9, 5'd9, 5'd7, 32'd11, 32'd12, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5'd9, 32'h55, 32'h55, 32'h00007FFF, 5'b10100};
        vecs[7] = '{3'd7, 5'd3, 5'd4, 5'd31, 32'd5, 32'd6, 1'b0, 16'h0, 1'b0, 1'b0, 5'd3, 32'h77, 32'd5, 32'd6, 5'b10110};

        idle_inputs();
        reset_n = 0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_a", out_a, 0);
        check("rst_b", out_b, 0);
        check("rst_ctrl", {27'd0, out_ctrl}, 0);
        check("rst_rd", {27'd0, out_rd}, 0);
        out_ready = 0;
        reset_n = 1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1; out_ready = 1;
            in_op = vecs[i].op; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_rd = vecs[i].rd;
            in_rs1_data = vecs[i].rs1_data; in_rs2_data = vecs[i].rs2_data;
            in_use_imm = vecs[i].use_imm; in_imm = vecs[i].imm; in_imm_signed = vecs[i].imm_signed;
            fwd_valid = vecs[i].fv; fwd_rd = vecs[i].frd; fwd_data = vecs[i].fdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 1);
            check($sformatf("vec%0d_a", i), out_a, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), out_b, vecs[i].exp_b);
            check($sformatf("vec%0d_ctrl", i), {27'd0, out_ctrl}, {27'd0, vecs[i].exp_ctrl});
            check($sformatf("vec%0d_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            @(negedge clk);
            in_valid = 0; fwd_valid = 0;
            @(posedge clk); #1;
            check($sformatf("vec%0d_drain", i), {31'd0, out_valid}, 0);
        end

        // Backpressure: SLT held for three cycles while SGE waits upstream
        @(negedge clk);
        drive_op(3'd4, 5'd10, 32'h44); out_ready = 1;
        @(posedge clk); #1;
        check("bp_cap_ctrl", {27'd0, out_ctrl}, 32'b10010);
        @(negedge clk);
        drive_op(3'd7, 5'd11, 32'h77); out_ready = 0;
        #1;
        check("bp_in_ready", {31'd0, in_ready}, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, out_valid}, 1);
            check("bp_hold_ctrl", {27'd0, out_ctrl}, 32'b10010);
            check("bp_hold_a", out_a, 32'h44);
            check("bp_hold_rd", {27'd0, out_rd}, 10);
            check("bp_hold_in_ready", {31'd0, in_ready}, 0);
        end
        @(negedge clk);
        out_ready = 1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        check("bp_next_ctrl", {27'd0, out_ctrl}, 32'b10110);
        check("bp_next_a", out_a, 32'h77);

        // Flush beats a simultaneous capture and drain
        @(negedge clk);
        drive_op(3'd1, 5'd20, 32'h99); flush = 1; out_ready = 1;
        @(posedge clk); #1;
        check("flush_valid", {31'd0, out_valid}, 0);
        check("flush_rd", {27'd0, out_rd}, 11);
        @(negedge clk);
        flush = 0; in_valid = 0;

        // Back-to-back stream of all eight ops
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_op(i[2:0], i[4:0], 32'(i * 3 + 1)); out_ready = 1;
            @(posedge clk); #1;
            check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 1);
            check($sformatf("stream%0d_ctrl", i), {27'd0, out_ctrl}, {27'd0, enc[i]});
            check($sformatf("stream%0d_rd", i), {27'd0, out_rd}, i);
        end
        @(negedge clk);
        in_valid = 0;

        // Async reset while holding
        drive_op(3'd5, 5'd12, 32'h5);
        out_ready = 0;
        @(posedge clk); #1;
        check("ar_held_valid", {31'd0, out_valid}, 1);
        in_valid = 0;
        #2;
        reset_n = 0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 0);
        check("ar_ctrl", {27'd0, out_ctrl}, 0);
        check("ar_rd", {27'd0, out_rd}, 0);
        @(negedge clk);
        reset_n = 1;
        idle_inputs();

        // Randomized run against the model
        m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0;
        for (int c = 0; c < 2000; c++) begin
            logic acc;
            @(negedge clk);
            flush         = ($urandom_range(0, 15) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            in_op         = 3'($urandom);
            in_rs1        = 5'($urandom_range(0, 3));
            in_rs2        = 5'($urandom_range(0, 3));
            in_rd         = 5'($urandom);
            in_rs1_data   = $urandom;
            in_rs2_data   = $urandom;
            in_use_imm    = ($urandom_range(0, 3) == 0);
            in_imm        = 16'($urandom);
            in_imm_signed = 1'($urandom);
            fwd_valid     = 1'($urandom);
            fwd_rd        = 5'($urandom_range(0, 3));
            fwd_data      = $urandom;
            #1;
            acc = !m_valid || out_ready;
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, acc});
            @(posedge clk); #1;
            if (flush) begin
                m_valid = 0;
            end else if (acc && in_valid) begin
                m_valid = 1;
                m_a     = pick(in_rs1, in_rs1_data);
                m_b     = in_use_imm ? (in_imm_signed ? {{16{in_imm[15]}}, in_imm} : {16'd0, in_imm})
                                     : pick(in_rs2, in_rs2_data);
                m_ctrl  = enc[in_op];
                m_rd    = in_rd;
            end else if (out_ready) begin
                m_valid = 0;
            end
            check("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("rnd_a", out_a, m_a);
                check("rnd_b", out_b, m_b);
                check("rnd_ctrl", {27'd0, out_ctrl}, {27'd0, m_ctrl});
                check("rnd_rd", {27'd0, out_rd}, {27'd0, m_rd});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ex_issue.md
Name: alu_ex_issue

Overview:
- Single-entry ID/EX pipeline register that feeds the arithmetic ALU (ADD, SUB, SEQ, SNE, SLT, SGT, SLE, SGE).
- Captures a decoded instruction and selects the immediate or register operand, with sign or zero extension.
- Applies one level of result bypass, then encodes the ALU op into the ALU's 5-bit select vector.
- Holds the outputs stable under a valid/ready handshake, so the ALU sees registered operands and control.

Parameters:
- XLEN, 32, operand/data width.
- RADDR, 5, register-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of held and incoming instruction.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept this cycle.
- in_op  input  3  0 ADD, 1 SUB, 2 SEQ, 3 SNE, 4 SLT, 5 SGT, 6 SLE, 7 SGE.
- in_rs1_data  input  XLEN  register-file operand A.
- in_rs2_data  input  XLEN  register-file operand B.
- in_rs1  input  RADDR  source address A.
- in_rs2  input  RADDR  source address B.
- in_rd  input  RADDR  destination address.
- in_use_imm  input  1  1 = operand B from immediate.
- in_imm  input  16  immediate field.
- in_imm_signed  input  1  1 = sign-extend imm, 0 = zero-extend.
- fwd_valid  input  1  downstream result valid for bypass.
- fwd_rd  input  RADDR  downstream result destination.
- fwd_data  input  XLEN  downstream result value.
- out_valid  output  1  ALU inputs valid.
- out_ready  input  1  ALU/next stage consumes this cycle.
- out_a  output  XLEN  ALU in1.
- out_b  output  XLEN  ALU in2.
- out_ctrl  output  5  {sel4,sel3,sel2,sel1,sel0} to the ALU.
- out_rd  output  RADDR  destination passed along.

Behaviour:
- Reset (reset_n=0, asynchronous): out_valid=0, out_a=0, out_b=0, out_ctrl=5'b00000, out_rd=0. in_ready reads 1 once reset deasserts.
- in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
- Capture when in_valid && in_ready && !flush. The output registers update on the next rising edge and out_valid=1; latency is 1 cycle.
- Hold: if out_valid && !out_ready, every output register is frozen and the upstream data is ignored.
- Drain: if out_ready && out_valid and there is no capture, out_valid->0. The data registers keep their values, which are don't-care.
- Flush: when flush=1, out_valid->0 on the next edge regardless of the other inputs, and nothing is captured that cycle. Flush has priority over capture and hold.
- Operand A: fwd_data if fwd_valid && fwd_rd==in_rs1 && in_rs1!=0, else in_rs1_data.
- Operand B:
  - If in_use_imm=1: {{16{in_imm[15]}},in_imm} when in_imm_signed=1, else {16'b0,in_imm}. No forwarding applies.
  - Otherwise: the same forwarding rule as operand A, using in_rs2/in_rs2_data.
- Register 0 is never forwarded. Forwarding is evaluated only in the capture cycle.
- Op encoding to out_ctrl {sel4..sel0}. Don't-care bits are driven 0:
  - ADD 00000
  - SUB 11000
  - SEQ 10000
  - SNE 10001
  - SLT 10010
  - SGT 10011
  - SLE 10100
  - SGE 10110
- Simultaneous capture and drain (out_valid=1, out_ready=1, in_valid=1): the new instruction replaces the old one with no bubble, giving full throughput of one per cycle.
- Reset asserted mid-hold: all outputs clear immediately and the held instruction is lost.
- No combinational path from in_* to out_*. in_ready depends only on out_valid and out_ready.

Test Plan:
- Reset then capture: reset_n low, then high. Issue in_op=1, rs1_data=10, rs2_data=3, rd=4, use_imm=0 -> next cycle out_valid=1, out_a=10, out_b=3, out_ctrl=11000, out_rd=4.
- Immediate extension:
  - op=0, use_imm=1, imm=16'hFFFE, signed=1 -> out_b=32'hFFFFFFFE, out_ctrl=00000.
  - Same with signed=0 -> out_b=32'h0000FFFE.
- Backpressure: capture op=4 (SLT), then hold out_ready=0 for 3 cycles while offering op=7 -> outputs stay op=4 values, out_ctrl=10010, in_ready=0. Raise out_ready -> next cycle out_ctrl=10110.
- Forwarding:
  - rs1=5, rs1_data=1, fwd_valid=1, fwd_rd=5, fwd_data=99 -> out_a=99.
  - Repeat with rs1=0 and fwd_rd=0 -> out_a=rs1_data.
- Flush priority: out_valid=1, in_valid=1, flush=1, out_ready=1 -> next cycle out_valid=0, out_rd unchanged. A back-to-back stream of 8 ops with out_ready=1 produces 8 consecutive out_valid cycles carrying the 8 encodings in order.
- Async reset mid-hold: out_valid=1 with out_ready=0, pulse reset_n low between edges -> out_valid=0 and out_ctrl=00000 immediately, before the next clock edge.
